// File: rtl/hood_mode_ctrl_if.sv
// Hood controller user-panel bundle: buttons and permissions in, mode/display status out.
interface hood_mode_ctrl_if #(
   parameter int unsigned NUM_LEVELS = 3
);
   logic                  power_on;
   logic                  menu_btn;
   logic [NUM_LEVELS-1:0] level_btn;
   logic                  clean_btn;
   logic                  boost_allowed;
   logic [2:0]            state;
   logic [2:0]            level;
   logic [NUM_LEVELS+1:0] led;
   logic [7:0]            remaining_sec;

   modport master (
      output power_on, menu_btn, level_btn, clean_btn, boost_allowed,
      input  state, level, led, remaining_sec
   );

   modport slave (
      input  power_on, menu_btn, level_btn, clean_btn, boost_allowed,
      output state, level, led, remaining_sec
   );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Cooker-hood mode controller: standby/arm/run/boost/self-clean with second-based countdowns.
// Optional boost re-entry lockout is compiled in with macro HOOD_BOOST_COOLDOWN_EN.
module hood_mode_ctrl #(
   parameter int unsigned NUM_LEVELS   = 3,
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned BOOST_SEC    = 60,
   parameter int unsigned CLEAN_SEC    = 180,
   parameter int unsigned COOLDOWN_SEC = 30
) (
   input logic             clk,
   input logic             rst,
   hood_mode_ctrl_if.slave bus
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned LW = NUM_LEVELS + 2;
   localparam logic [2:0]  TOP_LVL = 3'(NUM_LEVELS);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_STANDBY = 3'd1,
      S_ARMED   = 3'd2,
      S_RUN     = 3'd3,
      S_BOOST   = 3'd4,
      S_CLEAN   = 3'd5
   } state_e;

   if (NUM_LEVELS < 2 || NUM_LEVELS > 7 || CLK_HZ < 1 ||
       BOOST_SEC < 1 || BOOST_SEC > 255 || CLEAN_SEC < 1 || CLEAN_SEC > 255 ||
       COOLDOWN_SEC > 255) begin : g_bad_param
      $error("hood_mode_ctrl: parameter out of range");
   end

   state_e          state_q, state_d;
   logic [2:0]      level_q, level_d;
   logic [LW-1:0]   led_q, led_d;
   logic [7:0]      rem_q, rem_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            ret_flag_q, ret_flag_d;
   logic [2:0]      ret_lvl_q, ret_lvl_d;
   logic            menu_q;

   logic            menu_edge_c;
   logic            tick_c;
   logic            sel_valid_c;
   logic [2:0]      sel_lvl_c;
   logic            sel_top_c;
   logic            locked_c;
   logic            boost_ok_c;

   assign menu_edge_c = bus.menu_btn & ~menu_q;
   assign tick_c      = (presc_q == PW'(CLK_HZ - 1));
   assign sel_top_c   = sel_valid_c && (sel_lvl_c == TOP_LVL);
   assign boost_ok_c  = bus.boost_allowed && !locked_c;

   // Lowest-index pressed level button wins.
   always_comb begin
      sel_valid_c = 1'b0;
      sel_lvl_c   = 3'd0;
      for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
         if (bus.level_btn[i]) begin
            sel_valid_c = 1'b1;
            sel_lvl_c   = 3'(i + 1);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      rem_d      = rem_q;
      ret_flag_d = ret_flag_q;
      ret_lvl_d  = ret_lvl_q;

      if (!bus.power_on) begin
         state_d    = S_OFF;
         level_d    = 3'd0;
         rem_d      = 8'd0;
         ret_flag_d = 1'b0;
         ret_lvl_d  = 3'd0;
      end else begin
         case (state_q)
            S_OFF: state_d = S_STANDBY;
            S_STANDBY: if (menu_edge_c) state_d = S_ARMED;
            S_ARMED: begin
               if (menu_edge_c) begin
                  state_d = S_STANDBY;
               end else if (sel_valid_c) begin
                  if (!sel_top_c) begin
                     state_d = S_RUN;
                     level_d = sel_lvl_c;
                  end else if (boost_ok_c) begin
                     state_d    = S_BOOST;
                     level_d    = TOP_LVL;
                     rem_d      = 8'(BOOST_SEC);
                     ret_flag_d = 1'b0;
                     ret_lvl_d  = 3'd0;
                  end
               end else if (bus.clean_btn) begin
                  state_d = S_CLEAN;
                  rem_d   = 8'(CLEAN_SEC);
               end
            end
            S_RUN: begin
               if (menu_edge_c) begin
                  state_d = S_STANDBY;
                  level_d = 3'd0;
               end else if (sel_valid_c) begin
                  if (!sel_top_c) begin
                     level_d = sel_lvl_c;
                  end else if (boost_ok_c) begin
                     state_d    = S_BOOST;
                     level_d    = TOP_LVL;
                     rem_d      = 8'(BOOST_SEC);
                     ret_flag_d = 1'b0;
                     ret_lvl_d  = level_q;
                  end
               end
            end
            S_BOOST: begin
               // Expiry and loss of permission share the same exit rule.
               if (rem_q == 8'd0 || !bus.boost_allowed) begin
                  rem_d      = 8'd0;
                  ret_flag_d = 1'b0;
                  if (ret_flag_q && ret_lvl_q != 3'd0) begin
                     state_d = S_RUN;
                     level_d = ret_lvl_q;
                  end else begin
                     state_d = S_STANDBY;
                     level_d = 3'd0;
                  end
               end else begin
                  if (menu_edge_c) ret_flag_d = 1'b1;
                  if (tick_c)      rem_d      = rem_q - 8'd1;
               end
            end
            S_CLEAN: begin
               if (rem_q == 8'd0) begin
                  state_d = S_STANDBY;
               end else if (tick_c) begin
                  rem_d = rem_q - 8'd1;
               end
            end
            default: begin
               state_d = S_OFF;
               level_d = 3'd0;
               rem_d   = 8'd0;
            end
         endcase
      end
   end

   // Prescaler runs only while staying in a countdown state, so each entry restarts it.
   always_comb begin
      presc_d = '0;
      if ((state_d == S_BOOST || state_d == S_CLEAN) && state_d == state_q) begin
         presc_d = tick_c ? '0 : presc_q + PW'(1);
      end
   end

   always_comb begin
      led_d = '0;
      case (state_d)
         S_STANDBY, S_ARMED: led_d[0] = 1'b1;
         S_RUN, S_BOOST:     led_d = LW'(1) << level_d;
         S_CLEAN:            led_d[LW-1] = 1'b1;
         default:            led_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_OFF;
         level_q    <= 3'd0;
         led_q      <= '0;
         rem_q      <= 8'd0;
         presc_q    <= '0;
         ret_flag_q <= 1'b0;
         ret_lvl_q  <= 3'd0;
         menu_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         led_q      <= led_d;
         rem_q      <= rem_d;
         presc_q    <= presc_d;
         ret_flag_q <= ret_flag_d;
         ret_lvl_q  <= ret_lvl_d;
         menu_q     <= bus.menu_btn;
      end
   end

`ifdef HOOD_BOOST_COOLDOWN_EN
   logic [7:0]    lock_q, lock_d;
   logic [PW-1:0] cd_q, cd_d;
   logic          boost_exit_c;

   assign boost_exit_c = (state_q == S_BOOST) && (state_d != S_BOOST);
   assign locked_c     = (lock_q != 8'd0);

   // Lockout has its own second prescaler, aligned to the boost exit.
   always_comb begin
      lock_d = lock_q;
      cd_d   = cd_q;
      if (!bus.power_on || state_q == S_OFF) begin
         lock_d = 8'd0;
         cd_d   = '0;
      end else if (boost_exit_c) begin
         lock_d = 8'(COOLDOWN_SEC);
         cd_d   = '0;
      end else if (locked_c) begin
         if (cd_q == PW'(CLK_HZ - 1)) begin
            cd_d   = '0;
            lock_d = lock_q - 8'd1;
         end else begin
            cd_d = cd_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q <= 8'd0;
         cd_q   <= '0;
      end else begin
         lock_q <= lock_d;
         cd_q   <= cd_d;
      end
   end
`else
   assign locked_c = 1'b0;
`endif

   assign bus.state         = state_q;
   assign bus.level         = level_q;
   assign bus.led           = led_q;
   assign bus.remaining_sec = rem_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed scoreboard bench for hood_mode_ctrl (CLK_HZ=10, 3 levels, 3 s boost, 5 s clean, 4 s lockout).
module tb_hood_mode_ctrl;

   localparam int unsigned NL = 3;
   localparam int unsigned HZ = 10;
   localparam int unsigned BS = 3;
   localparam int unsigned CS = 5;
   localparam int unsigned CD = 4;

   localparam logic [2:0] OFF = 3'd0, SB = 3'd1, AR = 3'd2, RUN = 3'd3, BST = 3'd4, CLN = 3'd5;
   localparam logic [NL+1:0] L_0  = 5'b00000;
   localparam logic [NL+1:0] L_SB = 5'b00001;
   localparam logic [NL+1:0] L_1  = 5'b00010;
   localparam logic [NL+1:0] L_2  = 5'b00100;
   localparam logic [NL+1:0] L_3  = 5'b01000;
   localparam logic [NL+1:0] L_CL = 5'b10000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hood_mode_ctrl_if #(.NUM_LEVELS(NL)) bus ();

   hood_mode_ctrl #(
      .NUM_LEVELS(NL), .CLK_HZ(HZ), .BOOST_SEC(BS), .CLEAN_SEC(CS), .COOLDOWN_SEC(CD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [2:0]    st;
      logic [2:0]    lv;
      logic [NL+1:0] led;
      logic [7:0]    rem;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] st, input logic [2:0] lv,
                             input logic [NL+1:0] led, input logic [7:0] rem);
      exp_t e;
      e.st = st; e.lv = lv; e.led = led; e.rem = rem;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_out();
      exp_t  e;
      string t;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
         n_bad++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (exp_q.size() != 0) begin
         n_cmp--;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk({t, ".state"}, 8'(bus.state), 8'(e.st));
         chk({t, ".level"}, 8'(bus.level), 8'(e.lv));
         chk({t, ".led"},   8'(bus.led),   8'(e.led));
         chk({t, ".rem"},   bus.remaining_sec, e.rem);
      end
   endtask

   task automatic step(input string tag, input logic [2:0] st, input logic [2:0] lv,
                       input logic [NL+1:0] led, input logic [7:0] rem);
      expect_out(tag, st, lv, led, rem);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Walk a countdown from entry to remaining 0; optional menu pulse and level-button poke.
   task automatic countdown(input string tag, input int sec, input logic [2:0] st,
                            input logic [2:0] lv, input logic [NL+1:0] led,
                            input int menu_at, input int poke_at);
      for (int k = 1; k <= sec * int'(HZ); k++) begin
         bus.menu_btn  = (k == menu_at);
         bus.level_btn = (k == poke_at) ? 3'b011 : 3'b000;
         step($sformatf("%s_k%0d", tag, k), st, lv, led, 8'(sec - k / int'(HZ)));
      end
      bus.menu_btn  = 1'b0;
      bus.level_btn = 3'b000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      bus.power_on      = 1'b0;
      bus.menu_btn      = 1'b0;
      bus.level_btn     = 3'b000;
      bus.clean_btn     = 1'b0;
      bus.boost_allowed = 1'b0;

      step("reset", OFF, 3'd0, L_0, 8'd0);
      rst = 1'b0;
      step("off_hold", OFF, 3'd0, L_0, 8'd0);
      bus.power_on = 1'b1;
      step("power_up", SB, 3'd0, L_SB, 8'd0);

      // Basic run/level change/back to standby
      bus.menu_btn = 1'b1;
      step("arm", AR, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0; bus.level_btn = 3'b001;
      step("run_l1", RUN, 3'd1, L_1, 8'd0);
      bus.level_btn = 3'b010;
      step("run_l2", RUN, 3'd2, L_2, 8'd0);
      bus.level_btn = 3'b000; bus.menu_btn = 1'b1;
      step("run_menu", SB, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0;
      step("sb_idle", SB, 3'd0, L_SB, 8'd0);

      // Boost refused without permission, then boost with return
      bus.menu_btn = 1'b1;
      step("arm2", AR, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0; bus.level_btn = 3'b100;
      step("boost_denied", AR, 3'd0, L_SB, 8'd0);
      bus.level_btn = 3'b010;
      step("run_l2b", RUN, 3'd2, L_2, 8'd0);
      bus.boost_allowed = 1'b1; bus.level_btn = 3'b100;
      step("boost_in", BST, 3'd3, L_3, 8'd3);
      bus.level_btn = 3'b000;
      countdown("boost_ret", BS, BST, 3'd3, L_3, 5, 7);
      step("boost_back", RUN, 3'd2, L_2, 8'd0);

`ifdef HOOD_BOOST_COOLDOWN_EN
      bus.level_btn = 3'b100;
      for (int j = 1; j <= int'(CD * HZ); j++) begin
         step($sformatf("locked_j%0d", j), RUN, 3'd2, L_2, 8'd0);
      end
      step("unlocked", BST, 3'd3, L_3, 8'd3);
`else
      bus.level_btn = 3'b100;
      step("reboost", BST, 3'd3, L_3, 8'd3);
`endif
      bus.level_btn = 3'b000;
      countdown("boost_noret", BS, BST, 3'd3, L_3, 0, 0);
      step("boost_sb", SB, 3'd0, L_SB, 8'd0);

      // Full self-clean with ignored buttons
      bus.menu_btn = 1'b1;
      step("arm3", AR, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0; bus.clean_btn = 1'b1;
      step("clean_in", CLN, 3'd0, L_CL, 8'd5);
      countdown("clean", CS, CLN, 3'd0, L_CL, 3, 7);
      bus.clean_btn = 1'b0;
      step("clean_done", SB, 3'd0, L_SB, 8'd0);

      // Power loss mid-clean
      bus.menu_btn = 1'b1;
      step("arm4", AR, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0; bus.clean_btn = 1'b1;
      step("clean_in2", CLN, 3'd0, L_CL, 8'd5);
      bus.clean_btn = 1'b0;
      for (int k = 1; k <= 5; k++) step($sformatf("clean2_k%0d", k), CLN, 3'd0, L_CL, 8'd5);
      bus.power_on = 1'b0;
      step("power_off", OFF, 3'd0, L_0, 8'd0);
      bus.power_on = 1'b1;
      step("power_up2", SB, 3'd0, L_SB, 8'd0);

      // Lowest index wins; async reset mid-boost
      bus.menu_btn = 1'b1;
      step("arm5", AR, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0; bus.level_btn = 3'b111;
      step("multi_btn", RUN, 3'd1, L_1, 8'd0);
      bus.level_btn = 3'b100;
      step("boost_l1", BST, 3'd3, L_3, 8'd3);
      bus.level_btn = 3'b000;
      step("boost_l1_a", BST, 3'd3, L_3, 8'd3);
      step("boost_l1_b", BST, 3'd3, L_3, 8'd3);
      rst = 1'b1;
      #2;
      expect_out("async_rst", OFF, 3'd0, L_0, 8'd0);
      check_out();
      step("rst_hold", OFF, 3'd0, L_0, 8'd0);
      rst = 1'b0;
      step("rst_release", SB, 3'd0, L_SB, 8'd0);

      // Boost from ARMED, permission dropped; no return level so back to standby
      bus.menu_btn = 1'b1;
      step("arm6", AR, 3'd0, L_SB, 8'd0);
      bus.menu_btn = 1'b0; bus.level_btn = 3'b100;
      step("boost_armed", BST, 3'd3, L_3, 8'd3);
      bus.level_btn = 3'b000; bus.menu_btn = 1'b1;
      step("boost_menu", BST, 3'd3, L_3, 8'd3);
      bus.menu_btn = 1'b0;
      step("boost_c", BST, 3'd3, L_3, 8'd3);
      bus.boost_allowed = 1'b0;
      step("boost_drop", SB, 3'd0, L_SB, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
